// File: rtl/key_serializer.sv
// key_serializer: parallel-to-serial transmitter for the joypad key lines.
// Frame = START(1), D0..D7 (LSB first), even parity, STOP(0), each bit held
// CLKDIV clocks, with IDLE_GAP idle bit times (skey=0) between frames.
module key_serializer #(
    parameter int CLKDIV   = 16,
    parameter int IDLE_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       en,
    output logic       skey,
    output logic       busy,
    output logic       frame_done
);
    localparam int               DIV_W    = $clog2(CLKDIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [3:0]       GAP_LAST = 4'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        S_GAP,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic [3:0]       bitcnt, bitcnt_nx;
    logic [7:0]       shift, shift_nx;
    logic             par, par_nx;
    logic             skey_nx;
    logic             bit_end;

    assign bit_end    = (div == DIV_LAST);
    assign busy       = (state != S_GAP);
    assign frame_done = (state == S_STOP) && bit_end;

    // State, counters, snapshot and the registered line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_GAP;
            div    <= '0;
            bitcnt <= '0;
            shift  <= '0;
            par    <= 1'b0;
            skey   <= 1'b0;
        end else begin
            state  <= state_nx;
            div    <= div_nx;
            bitcnt <= bitcnt_nx;
            shift  <= shift_nx;
            par    <= par_nx;
            skey   <= skey_nx;
        end
    end

    // Next-state logic: every transition happens on a bit boundary, and the
    // line level for the new bit is loaded on that same edge.
    always_comb begin
        state_nx  = state;
        div_nx    = bit_end ? '0 : div + 1'b1;
        bitcnt_nx = bitcnt;
        shift_nx  = shift;
        par_nx    = par;
        skey_nx   = skey;
        case (state)
            S_GAP: begin
                if (bit_end && bitcnt == GAP_LAST) begin
                    // Gap complete: park at terminal count until en is seen.
                    div_nx = div;
                    if (en) begin
                        state_nx  = S_START;
                        div_nx    = '0;
                        bitcnt_nx = '0;
                        shift_nx  = key;
                        par_nx    = ^key;
                        skey_nx   = 1'b1;
                    end
                end else if (bit_end) begin
                    bitcnt_nx = bitcnt + 4'd1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nx  = S_DATA;
                    bitcnt_nx = '0;
                    skey_nx   = shift[0];
                    shift_nx  = shift >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bitcnt == 4'd7) begin
                        state_nx = S_PARITY;
                        skey_nx  = par;
                    end else begin
                        bitcnt_nx = bitcnt + 4'd1;
                        skey_nx   = shift[0];
                        shift_nx  = shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nx = S_STOP;
                    skey_nx  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_nx  = S_GAP;
                    bitcnt_nx = '0;
                    skey_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = S_GAP;
                skey_nx  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_key_serializer.sv
// Bench for key_serializer: two instances (CLKDIV=4/IDLE_GAP=2 and
// CLKDIV=2/IDLE_GAP=1) share stimulus; a frame-level model predicts the
// outputs of both every cycle, and literal checks pin the model.
module tb_key_serializer;
    localparam int CD0 = 4, GP0 = 2, CD1 = 2, GP1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] key;
    logic [1:0] skey, busy, fd;

    int nvec = 0;
    int nerr = 0;
    int t    = 0;

    logic [1:0] hs [0:511];
    logic [1:0] hb [0:511];
    logic [1:0] hf [0:511];

    key_serializer #(.CLKDIV(CD0), .IDLE_GAP(GP0)) u0 (
        .clk(clk), .rst(rst), .key(key), .en(en),
        .skey(skey[0]), .busy(busy[0]), .frame_done(fd[0]));

    key_serializer #(.CLKDIV(CD1), .IDLE_GAP(GP1)) u1 (
        .clk(clk), .rst(rst), .key(key), .en(en),
        .skey(skey[1]), .busy(busy[1]), .frame_done(fd[1]));

    always #5 clk = ~clk;

    function automatic int cd(int i);
        return (i == 0) ? CD0 : CD1;
    endfunction

    function automatic int gp(int i);
        return (i == 0) ? GP0 : GP1;
    endfunction

    // Frame bits in transmit order, index 0 = START.
    function automatic logic [10:0] frame_bits(logic [7:0] k);
        return {1'b0, ^k, k, 1'b1};
    endfunction

    // Model: either idle counting gap clocks, or at clock f of an 11-bit frame.
    int          m_infr [2];
    int          m_f    [2];
    int          m_gap  [2];
    logic [10:0] m_bits [2];

    // Advance the frame-level model one clock per instance.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_infr[i] <= 0;
                m_f[i]    <= 0;
                m_gap[i]  <= 0;
                m_bits[i] <= '0;
            end else if (m_infr[i] != 0) begin
                if (m_f[i] == 11 * cd(i) - 1) begin
                    m_infr[i] <= 0;
                    m_gap[i]  <= 0;
                end else begin
                    m_f[i] <= m_f[i] + 1;
                end
            end else if (m_gap[i] < gp(i) * cd(i) - 1) begin
                m_gap[i] <= m_gap[i] + 1;
            end else if (en) begin
                m_infr[i] <= 1;
                m_f[i]    <= 0;
                m_bits[i] <= frame_bits(key);
            end
        end
    end

    function automatic int exp_skey(int i);
        if (m_infr[i] == 0) return 0;
        return int'(m_bits[i][m_f[i] / cd(i)]);
    endfunction

    function automatic int exp_fd(int i);
        return (m_infr[i] != 0 && m_f[i] == 11 * cd(i) - 1) ? 1 : 0;
    endfunction

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", nm, act, exp, t, $time);
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("skey%0d", i), int'(skey[i]), exp_skey(i));
            chk($sformatf("busy%0d", i), int'(busy[i]), m_infr[i]);
            chk($sformatf("frame_done%0d", i), int'(fd[i]), exp_fd(i));
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
        cmp_all();
        if (t < 512) begin
            hs[t] = skey; hb[t] = busy; hf[t] = fd;
        end
    endtask

    task automatic release_rst();
        rst = 1'b1;
        t = 0;
        hs[0] = skey; hb[0] = busy; hf[0] = fd;
    endtask

    initial begin
        logic [10:0] seq_a5;
        int cnt_f, cnt_b, cnt_q;
        seq_a5 = 11'b00101001011;
        rst = 1'b0; en = 1'b1; key = 8'hA5;
        step(); step();
        chk("reset_skey", int'(skey), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fd",   int'(fd),   0);

        // Frame sequence with mid-frame key change, en drop, en re-raise.
        release_rst();
        while (t < 221) begin
            step();
            if (t == 20)  key = 8'h01;
            if (t == 120) en  = 1'b0;
            if (t == 220) en  = 1'b1;
        end
        chk("restart_skey", int'(skey), 3);
        chk("restart_busy", int'(busy), 3);

        for (int j = 0; j < 8; j++) chk("first_gap", int'(hs[j][0]), 0);
        for (int b = 0; b < 11; b++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("a5_bit%0d", b), int'(hs[8 + 4*b + c][0]), int'(seq_a5[b]));
        cnt_f = 0; cnt_b = 0;
        for (int j = 0; j < 60; j++) begin
            cnt_f += int'(hf[j][0]);
            cnt_b += int'(hb[j][0]);
        end
        chk("fd_count_f1", cnt_f, 1);
        chk("fd_at_51", int'(hf[51][0]), 1);
        chk("busy_len_f1", cnt_b, 44);
        chk("start_at_60", int'({hs[59][0], hs[60][0]}), 1);
        chk("d0_key01", int'(hs[64][0]), 1);
        chk("parity_key01", int'(hs[96][0]), 1);
        chk("start_at_112", int'({hs[111][0], hs[112][0]}), 1);
        chk("cd2_start_at_2", int'({hs[1][1], hs[2][1]}), 1);
        chk("cd2_d6", int'(hs[16][1]), 0);
        chk("cd2_d7", int'({hs[18][1], hs[19][1]}), 3);
        chk("cd2_start_at_26", int'({hs[25][1], hs[26][1]}), 1);
        cnt_f = 0; cnt_q = 0;
        for (int j = 112; j <= 220; j++) cnt_f += int'(hf[j][0]);
        for (int j = 156; j <= 220; j++) cnt_q += int'(hs[j][0] | hb[j][0]);
        chk("fd_count_en_off", cnt_f, 1);
        chk("idle_after_en_off", cnt_q, 0);

        // Async reset during PARITY of the frame that started at t=221.
        while (t < 258) step();
        rst = 1'b0;
        #1;
        chk("async_rst_skey", int'(skey[0]), 0);
        chk("async_rst_busy", int'(busy[0]), 0);
        chk("async_rst_fd",   int'(fd[0]),   0);
        cmp_all();
        step(); step(); step();
        release_rst();
        while (t < 12) step();
        for (int j = 0; j < 8; j++) chk("gap_after_rst", int'(hs[j][0]), 0);
        chk("start_after_rst", int'(hs[8][0]), 1);
        chk("cd2_start_after_rst", int'(hs[2][1]), 1);

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            step();
            if ($urandom_range(0, 7) == 0)  key = 8'($urandom);
            if ($urandom_range(0, 63) == 0) en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b0;
                #2;
                cmp_all();
                step();
                rst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
